// File: rtl/byte_burst_read_ctrl.sv
// Burst reader: fetches 16-bit words as two byte reads {word_addr, half}, high byte first, and hands each word downstream.
// Latency: first word_valid 4 cycles after the start edge, 4 cycles per word, done 4N+1 cycles after start.
// Backpressure: OUT holds word_data/index until o_word_ready; no memory reads are issued while stalled.
module byte_burst_read_ctrl #(
    parameter int WORD_AW = 6,
    parameter int BYTE_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [WORD_AW-1:0]   i_base_addr,
    input  logic [WORD_AW:0]     i_num_words,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_mem_en,
    output logic [WORD_AW:0]     o_mem_addr,
    input  logic [BYTE_W-1:0]    i_mem_rdata,
    output logic [2*BYTE_W-1:0]  o_word_data,
    output logic                 o_word_valid,
    input  logic                 i_word_ready,
    output logic [WORD_AW-1:0]   o_word_index
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_HI,
        S_RD_LO,
        S_CAP_LO,
        S_OUT,
        S_DONE
    } state_t;

    localparam logic [WORD_AW-1:0] PTR_ONE = 1;
    localparam logic [WORD_AW:0]   REM_ONE = 1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WORD_AW-1:0]  r_ptr;
    logic [WORD_AW-1:0]  w_ptr_nxt;
    logic [WORD_AW:0]    r_rem;
    logic [WORD_AW:0]    w_rem_nxt;
    logic [BYTE_W-1:0]   r_hi;
    logic [BYTE_W-1:0]   r_lo;
    logic                r_mem_en;
    logic [WORD_AW:0]    r_mem_addr;
    logic                w_mem_en_nxt;
    logic [WORD_AW:0]    w_mem_addr_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_rem_nxt   = r_rem;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (|i_num_words) begin
                        w_ptr_nxt   = i_base_addr;
                        w_rem_nxt   = i_num_words;
                        w_state_nxt = S_RD_HI;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_RD_HI:  w_state_nxt = S_RD_LO;
            S_RD_LO:  w_state_nxt = S_CAP_LO;
            S_CAP_LO: w_state_nxt = S_OUT;
            S_OUT: begin
                if (i_word_ready) begin
                    if (r_rem == REM_ONE) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_ptr_nxt   = r_ptr + PTR_ONE;
                        w_rem_nxt   = r_rem - REM_ONE;
                        w_state_nxt = S_RD_HI;
                    end
                end
            end
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Memory strobes are registered from the next state so they line up with RD_HI/RD_LO.
    always_comb begin
        w_mem_en_nxt   = (w_state_nxt == S_RD_HI) || (w_state_nxt == S_RD_LO);
        w_mem_addr_nxt = r_mem_addr;
        if (w_mem_en_nxt) begin
            w_mem_addr_nxt = {w_ptr_nxt, (w_state_nxt == S_RD_LO)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_rem      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_mem_en   <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_rem      <= w_rem_nxt;
            r_mem_en   <= w_mem_en_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            if (r_state == S_RD_LO) begin
                r_hi <= i_mem_rdata;
            end
            if (r_state == S_CAP_LO) begin
                r_lo <= i_mem_rdata;
            end
        end
    end

    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = (r_state == S_DONE);
    assign o_word_valid = (r_state == S_OUT);
    assign o_word_data  = {r_hi, r_lo};
    assign o_word_index = r_ptr;
    assign o_mem_en     = r_mem_en;
    assign o_mem_addr   = r_mem_addr;

endmodule
